// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order-retire circular reorder buffer with flush on mispredict/exception
module reorder_buffer #(
    parameter int NUM_ROB_ENTS = 64,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 4,
    parameter int NUM_FUS      = 4,
    parameter int NUM_AREGS    = 32,
    parameter int NUM_PREGS    = 128,
    localparam int AW = $clog2(NUM_AREGS),
    localparam int PW = $clog2(NUM_PREGS),
    localparam int IW = $clog2(NUM_ROB_ENTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DISP_WIDTH-1:0]        disp_valid,
    input  logic [DISP_WIDTH*AW-1:0]     disp_dst_areg,
    input  logic [DISP_WIDTH*PW-1:0]     disp_dst_preg,
    input  logic [DISP_WIDTH*32-1:0]     disp_pc,
    output logic                         disp_ready,
    output logic [DISP_WIDTH*IW-1:0]     disp_rob_idx,
    input  logic [NUM_FUS-1:0]           wb_valid,
    input  logic [NUM_FUS*IW-1:0]        wb_rob_idx,
    input  logic [NUM_FUS-1:0]           wb_exception,
    input  logic [NUM_FUS-1:0]           wb_br_mispred,
    output logic [RETIRE_WIDTH-1:0]      ret_valid,
    output logic [RETIRE_WIDTH*AW-1:0]   ret_dst_areg,
    output logic [RETIRE_WIDTH*PW-1:0]   ret_dst_preg,
    output logic [RETIRE_WIDTH*32-1:0]   ret_pc,
    output logic                         flush_valid,
    output logic                         flush_is_exc,
    output logic [31:0]                  flush_pc,
    output logic [IW:0]                  rob_count
);

    localparam logic [IW:0] ENTS = (IW+1)'(NUM_ROB_ENTS);
    localparam logic [IW:0] DW   = (IW+1)'(DISP_WIDTH);

    logic [NUM_ROB_ENTS-1:0] ent_valid, ent_done, ent_exc, ent_mis;
    logic [AW-1:0]           ent_areg [NUM_ROB_ENTS];
    logic [PW-1:0]           ent_preg [NUM_ROB_ENTS];
    logic [31:0]             ent_pc   [NUM_ROB_ENTS];
    logic [IW-1:0]           head, tail;

    logic [IW:0]             n_disp, n_ret;
    logic [NUM_ROB_ENTS-1:0] disp_set, wb_set, wb_exc_set, wb_mis_set, ret_clr;
    logic [IW-1:0]           ridx, widx;
    logic                    scan_stop;

    // Credit check uses registered occupancy only; same-cycle retire gives no credit.
    assign disp_ready = (ENTS - rob_count) >= DW;

    // Compact valid dispatch lanes onto tail, tail+1, ...
    always_comb begin
        n_disp       = '0;
        disp_set     = '0;
        disp_rob_idx = '0;
        for (int l = 0; l < DISP_WIDTH; l++) begin
            if (disp_valid[l]) begin
                disp_rob_idx[l*IW +: IW] = tail + n_disp[IW-1:0];
                if (disp_ready) disp_set[tail + n_disp[IW-1:0]] = 1'b1;
                n_disp = n_disp + 1'b1;
            end
        end
        if (!disp_ready) n_disp = '0;
    end

    // Merge all writeback ports into per-entry masks so same-index hits OR their flags.
    always_comb begin
        wb_set     = '0;
        wb_exc_set = '0;
        wb_mis_set = '0;
        widx       = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            widx = wb_rob_idx[f*IW +: IW];
            if (wb_valid[f] && ent_valid[widx]) begin
                wb_set[widx]     = 1'b1;
                wb_exc_set[widx] = wb_exc_set[widx] | wb_exception[f];
                wb_mis_set[widx] = wb_mis_set[widx] | wb_br_mispred[f];
            end
        end
    end

    // Retire scan from head; a flagged head entry raises flush instead.
    always_comb begin
        ret_valid    = '0;
        ret_dst_areg = '0;
        ret_dst_preg = '0;
        ret_pc       = '0;
        flush_valid  = 1'b0;
        flush_is_exc = 1'b0;
        flush_pc     = '0;
        ret_clr      = '0;
        n_ret        = '0;
        scan_stop    = 1'b0;
        ridx         = head;
        if (ent_valid[head] && ent_done[head] && (ent_exc[head] || ent_mis[head])) begin
            flush_valid = 1'b1;
            flush_pc    = ent_pc[head];
            if (ent_exc[head]) begin
                flush_is_exc = 1'b1;
            end else begin
                ret_valid[0]       = 1'b1;
                ret_dst_areg[0 +: AW] = ent_areg[head];
                ret_dst_preg[0 +: PW] = ent_preg[head];
                ret_pc[0 +: 32]       = ent_pc[head];
                n_ret              = (IW+1)'(1);
            end
        end else begin
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                ridx = head + IW'(k);
                if (!scan_stop && ent_valid[ridx] && ent_done[ridx] &&
                    !ent_exc[ridx] && !ent_mis[ridx]) begin
                    ret_valid[k]             = 1'b1;
                    ret_dst_areg[k*AW +: AW] = ent_areg[ridx];
                    ret_dst_preg[k*PW +: PW] = ent_preg[ridx];
                    ret_pc[k*32 +: 32]       = ent_pc[ridx];
                    ret_clr[ridx]            = 1'b1;
                    n_ret                    = n_ret + 1'b1;
                end else begin
                    scan_stop = 1'b1;
                end
            end
        end
    end

    // Entry status bits, pointers and occupancy; flush empties the whole buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            ent_done  <= '0;
            ent_exc   <= '0;
            ent_mis   <= '0;
            head      <= '0;
            tail      <= '0;
            rob_count <= '0;
        end else if (flush_valid) begin
            ent_valid <= '0;
            ent_done  <= '0;
            ent_exc   <= '0;
            ent_mis   <= '0;
            head      <= '0;
            tail      <= '0;
            rob_count <= '0;
        end else begin
            ent_valid <= (ent_valid & ~ret_clr) | disp_set;
            ent_done  <= (ent_done | wb_set) & ~ret_clr & ~disp_set;
            ent_exc   <= (ent_exc | wb_exc_set) & ~ret_clr & ~disp_set;
            ent_mis   <= (ent_mis | wb_mis_set) & ~ret_clr & ~disp_set;
            head      <= head + n_ret[IW-1:0];
            tail      <= tail + n_disp[IW-1:0];
            rob_count <= rob_count + n_disp - n_ret;
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int l = 0; l < DISP_WIDTH; l++) begin
            if (disp_valid[l] && disp_ready && !flush_valid) begin
                ent_areg[disp_rob_idx[l*IW +: IW]] <= disp_dst_areg[l*AW +: AW];
                ent_preg[disp_rob_idx[l*IW +: IW]] <= disp_dst_preg[l*PW +: PW];
                ent_pc[disp_rob_idx[l*IW +: IW]]   <= disp_pc[l*32 +: 32];
            end
        end
    end

    // Requests while not ready are dropped; flag them in simulation.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|disp_valid) && !disp_ready))
                else $warning("reorder_buffer: dispatch request while disp_ready=0 ignored");
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized bench for reorder_buffer against a queue model
module tb_reorder_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   disp_valid;
    logic [9:0]   disp_dst_areg;
    logic [13:0]  disp_dst_preg;
    logic [63:0]  disp_pc;
    logic         disp_ready;
    logic [11:0]  disp_rob_idx;
    logic [3:0]   wb_valid;
    logic [23:0]  wb_rob_idx;
    logic [3:0]   wb_exception;
    logic [3:0]   wb_br_mispred;
    logic [3:0]   ret_valid;
    logic [19:0]  ret_dst_areg;
    logic [27:0]  ret_dst_preg;
    logic [127:0] ret_pc;
    logic         flush_valid;
    logic         flush_is_exc;
    logic [31:0]  flush_pc;
    logic [6:0]   rob_count;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_dst_areg(disp_dst_areg),
        .disp_dst_preg(disp_dst_preg), .disp_pc(disp_pc),
        .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
        .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx),
        .wb_exception(wb_exception), .wb_br_mispred(wb_br_mispred),
        .ret_valid(ret_valid), .ret_dst_areg(ret_dst_areg),
        .ret_dst_preg(ret_dst_preg), .ret_pc(ret_pc),
        .flush_valid(flush_valid), .flush_is_exc(flush_is_exc),
        .flush_pc(flush_pc), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [4:0]  areg;
        logic [6:0]  preg;
        logic [31:0] pc;
        bit          done;
        bit          exc;
        bit          mis;
    } ent_t;

    ent_t q[$];
    int   mtail;
    int   exp_nret;
    bit   exp_flush;
    bit   exp_ready;
    int   n_asserts = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        disp_valid    = '0;
        disp_dst_areg = '0;
        disp_dst_preg = '0;
        disp_pc       = '0;
        wb_valid      = '0;
        wb_rob_idx    = '0;
        wb_exception  = '0;
        wb_br_mispred = '0;
    endtask

    task automatic drive_disp(input logic [1:0] v);
        disp_valid    = v;
        disp_dst_areg = 10'($urandom);
        disp_dst_preg = 14'($urandom);
        disp_pc       = {$urandom, $urandom};
    endtask

    task automatic drive_wb(input int port, input int idx, input bit exc, input bit mis);
        wb_valid[port]          = 1'b1;
        wb_rob_idx[port*6 +: 6] = 6'(idx);
        wb_exception[port]      = exc;
        wb_br_mispred[port]     = mis;
    endtask

    // Expected outputs from the queue model: oldest entry at q[0].
    task automatic eval_outputs();
        int         pre = 0;
        logic [3:0] ev = '0;
        bit         exc_flag = 0;
        exp_ready = (64 - q.size()) >= 2;
        check("disp_ready", disp_ready, exp_ready);
        check("rob_count", rob_count, q.size());
        for (int l = 0; l < 2; l++) begin
            int e = 0;
            if (disp_valid[l]) begin
                e = (mtail + pre) % 64;
                pre++;
            end
            check($sformatf("disp_rob_idx[%0d]", l), disp_rob_idx[l*6 +: 6], e);
        end
        exp_nret  = 0;
        exp_flush = 0;
        if (q.size() > 0 && q[0].done && (q[0].exc || q[0].mis)) begin
            exp_flush = 1;
            exc_flag  = q[0].exc;
            if (!q[0].exc) begin
                ev[0]    = 1'b1;
                exp_nret = 1;
            end
        end else begin
            while (exp_nret < 4 && exp_nret < q.size() && q[exp_nret].done &&
                   !q[exp_nret].exc && !q[exp_nret].mis) begin
                ev[exp_nret] = 1'b1;
                exp_nret++;
            end
        end
        check("ret_valid", ret_valid, ev);
        check("flush_valid", flush_valid, exp_flush);
        check("flush_is_exc", flush_is_exc, exp_flush && exc_flag);
        check("flush_pc", flush_pc, exp_flush ? q[0].pc : 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ret_areg[%0d]", k), ret_dst_areg[k*5 +: 5],  ev[k] ? q[k].areg : 5'd0);
            check($sformatf("ret_preg[%0d]", k), ret_dst_preg[k*7 +: 7],  ev[k] ? q[k].preg : 7'd0);
            check($sformatf("ret_pc[%0d]", k),   ret_pc[k*32 +: 32],      ev[k] ? q[k].pc : 32'd0);
        end
    endtask

    task automatic model_edge();
        if (exp_flush) begin
            q.delete();
            mtail = 0;
            return;
        end
        for (int f = 0; f < 4; f++) begin
            if (wb_valid[f]) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].idx == int'(wb_rob_idx[f*6 +: 6])) begin
                        q[j].done = 1;
                        q[j].exc  = q[j].exc | wb_exception[f];
                        q[j].mis  = q[j].mis | wb_br_mispred[f];
                    end
                end
            end
        end
        for (int n = 0; n < exp_nret; n++) void'(q.pop_front());
        if (exp_ready) begin
            for (int l = 0; l < 2; l++) begin
                if (disp_valid[l]) begin
                    ent_t e;
                    e.idx  = mtail;
                    e.areg = disp_dst_areg[l*5 +: 5];
                    e.preg = disp_dst_preg[l*7 +: 7];
                    e.pc   = disp_pc[l*32 +: 32];
                    e.done = 0;
                    e.exc  = 0;
                    e.mis  = 0;
                    q.push_back(e);
                    mtail = (mtail + 1) % 64;
                end
            end
        end
    endtask

    // Inputs are already driven; check, clock, update model, return at the falling edge.
    task automatic cycle();
        #1;
        eval_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_rob_count", rob_count, 7'd0);
        check("rst_disp_ready", disp_ready, 1'b1);
        check("rst_ret_valid", ret_valid, 4'd0);
        check("rst_flush_valid", flush_valid, 1'b0);
        rst = 1'b0;
        q.delete();
        mtail = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2;
        do_reset();

        // Fill the buffer two per cycle, then a request against a full buffer.
        for (int c = 0; c < 32; c++) begin
            drive_disp(2'b11);
            cycle();
        end
        #1;
        check("t1_full_count", rob_count, 7'd64);
        check("t1_full_ready", disp_ready, 1'b0);
        drive_disp(2'b11);
        cycle();

        // Complete every entry four per cycle, drain, then re-dispatch from index 0.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 4; f++) drive_wb(f, c*4 + f, 0, 0);
            cycle();
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
        check("t3_drained", rob_count, 7'd0);
        drive_disp(2'b11);
        #1;
        check("t3_idx_reuse", disp_rob_idx, {6'd1, 6'd0});
        cycle();
        cycle();
        cycle();

        // Out-of-order completion: nothing retires until the head is done.
        do_reset();
        drive_disp(2'b11); cycle();
        drive_disp(2'b11); cycle();
        drive_wb(0, 3, 0, 0); cycle();
        drive_wb(1, 1, 0, 0); cycle();
        drive_wb(2, 2, 0, 0); cycle();
        drive_wb(3, 0, 0, 0); cycle();
        #1;
        check("t2_ret_all", ret_valid, 4'b1111);
        cycle();
        cycle();

        // Mispredict at idx5 retires 0..3, then 4, then the branch alone with flush.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_disp(2'b11);
            cycle();
        end
        drive_wb(0, 4, 0, 0); drive_wb(1, 5, 0, 1); drive_wb(2, 6, 0, 0); drive_wb(3, 7, 0, 0);
        cycle();
        drive_wb(0, 0, 0, 0); drive_wb(1, 1, 0, 0); drive_wb(2, 2, 0, 0); drive_wb(3, 3, 0, 0);
        cycle();
        for (int c = 0; c < 4; c++) cycle();
        #1;
        check("t4_count_after_flush", rob_count, 7'd0);

        // Exception at head flushes and drops the same-cycle dispatch.
        do_reset();
        drive_disp(2'b11); cycle();
        drive_wb(0, 0, 1, 1); cycle();
        drive_disp(2'b11);
        #1;
        check("t5_flush_exc", {flush_valid, flush_is_exc, ret_valid}, {1'b1, 1'b1, 4'b0000});
        cycle();
        cycle();

        // Asynchronous reset between edges with ten entries occupied.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive_disp(2'b11);
            cycle();
        end
        for (int f = 0; f < 4; f++) drive_wb(f, f, 0, 0);
        cycle();
        #1;
        eval_outputs();
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_count", rob_count, 7'd0);
        check("t6_async_ret", ret_valid, 4'd0);
        check("t6_async_ready", disp_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mtail = 0;
        drive_disp(2'b11);
        cycle();
        cycle();

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ((64 - q.size()) >= 2) drive_disp(2'($urandom));
            for (int f = 0; f < 4; f++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int idx;
                    if (q.size() > 0 && $urandom_range(0, 9) < 8)
                        idx = q[$urandom_range(0, q.size() - 1)].idx;
                    else
                        idx = $urandom_range(0, 63);
                    drive_wb(f, idx, $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
